dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, 4, consecutive cycles a contended external request loses before it is forced to win.
REQ-002 Parameter LOCK_MAX, 8, maximum consecutive cycles an external locked burst holds the grant.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cpu_req, cpu_we  input  1 each  MEM-stage access request; write when cpu_we=1.
REQ-006 cpu_addr, cpu_wdata  input  32 each  MEM-stage byte address, store data.
REQ-007 cpu_mask  input  4  MEM-stage byte-lane mask.
REQ-008 cpu_gnt  output  1  CPU access performed this cycle.
REQ-009 cpu_stall  output  1  cpu_req & ~cpu_gnt; holds the pipeline.
REQ-010 cpu_rvalid, cpu_rdata  output  1/32  registered read return for the CPU.
REQ-011 ext_req, ext_we, ext_lock  input  1 each  external (loader/debug/DMA) request, write, burst lock.
REQ-012 ext_addr, ext_wdata  input  32 each; ext_mask  input  4  external address, data, lanes.
REQ-013 ext_gnt, ext_rvalid  output  1 each; ext_rdata  output  32  external grant and registered read return.
REQ-014 mem_writeEn  output  1; mem_mMask  output  4; mem_addr, mem_writeData  output  32; mem_readData  input  32  shared single-port Memory port (mem_addr drives both writeAddr and readAddr).
REQ-015 link_active, link_addr  input  1/32  current LL reservation from the MEM stage.
REQ-016 link_kill  output  1  pulse: reservation must be cleared.

Function
REQ-017 Grant is combinational from current inputs and registered state; at most one of cpu_gnt/ext_gnt is high in any cycle.
REQ-018 Priority: (a) if state=ARB_EXT_LOCK, ext_req=1, ext_lock=1 and lock_cnt<LOCK_MAX, grant ext; else (b) if both request and starve_cnt=STARVE_LIMIT, grant ext; else (c) if cpu_req, grant cpu; else (d) if ext_req, grant ext; else no grant.
REQ-019 With no grant: mem_writeEn=0, mem_mMask=0, mem_addr=0, mem_writeData=0.
REQ-020 With a grant, the mem_* outputs carry the winner's addr/wdata/mask; mem_writeEn equals the winner's we.
REQ-021 States ARB_IDLE, ARB_CPU, ARB_EXT, ARB_EXT_LOCK; next state = ARB_EXT_LOCK if ext is granted with ext_lock=1, ARB_EXT if ext is granted otherwise, ARB_CPU if cpu is granted, ARB_IDLE if nothing is granted.
REQ-022 starve_cnt (width clog2(STARVE_LIMIT+1)) increments, saturating at STARVE_LIMIT, when ext_req=1 and ext_gnt=0; it clears when ext_gnt=1 or ext_req=0.
REQ-023 lock_cnt increments on each ext grant in ARB_EXT_LOCK and clears on any other next state; at LOCK_MAX the lock is broken for one arbitration and normal priority applies.
REQ-024 Read latency is 1 cycle: a granted read (we=0) registers mem_readData into the winner's rdata and sets the winner's rvalid=1 for exactly the next cycle; a granted write leaves rvalid=0.
REQ-025 rdata holds its last value when rvalid=0.
REQ-026 link_kill=1 in the same cycle as an ext grant with ext_we=1, link_active=1 and ext_addr[31:2]=link_addr[31:2]; otherwise 0, CPU writes never assert it.
REQ-027 If ext_req drops mid-lock, the lock ends immediately and the cpu wins the same cycle if requesting.

Reset
REQ-028 On rst: state=ARB_IDLE, starve_cnt=0, lock_cnt=0, cpu_rvalid=ext_rvalid=0, cpu_rdata=ext_rdata=0.
REQ-029 While rst=1, all grants, mem_writeEn and link_kill are 0; a request pending at reset release is arbitrated from ARB_IDLE, and no rvalid is produced for an access cut off by reset.

Structure
REQ-030 Package dmem_arb_pkg holds arb_state_t (the four states) and the default STARVE_LIMIT/LOCK_MAX constants.
REQ-031 No sub-module; Memory stays instantiated beside the arbiter, driven from the mem_* port.

Verification
REQ-032 cpu read 0x100 alone, mem returns 0xDEADBEEF -> cpu_gnt same cycle, next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF.
REQ-033 cpu and ext both request continuously -> cpu wins 4 cycles, ext wins cycle 5, pattern repeats; cpu_stall=1 only in ext cycles.
REQ-034 ext_lock=1 burst of 12 writes with cpu requesting -> ext holds grant 8 cycles, cpu granted once, ext resumes.
REQ-035 link_active=1, link_addr=0x200; ext write 0x202 -> link_kill=1 that cycle; cpu write 0x200 -> link_kill=0.
REQ-036 rst asserted mid-lock with pending read -> all outputs 0 immediately, no rvalid after release, first post-reset contended cycle goes to cpu.
REQ-037 Random two-requester traffic against a reference memory model -> data matches, grants mutually exclusive, no ext wait exceeds STARVE_LIMIT+1 cycles.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   arb_state_t      : arbiter FSM states
//   STARVE_LIMIT_DEF : default number of contended losses before the
//                      external requester is forced to win
//   LOCK_MAX_DEF     : default maximum length of an external locked burst
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_CPU      = 2'd1,
    ARB_EXT      = 2'd2,
    ARB_EXT_LOCK = 2'd3
  } arb_state_t;

  localparam int STARVE_LIMIT_DEF = 4;
  localparam int LOCK_MAX_DEF     = 8;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter and its surroundings.
//   cpu_*  : MEM-stage request (req/we/addr/wdata/mask) and grant, stall,
//            registered read return (rvalid/rdata)
//   ext_*  : loader/debug/DMA request incl. burst lock, grant and read return
//   mem_*  : shared single-port memory; mem_addr serves read and write
//   link_* : LL reservation from the MEM stage and the kill pulse back
// Modport slave is the arbiter side, master is the environment side.
interface dmem_arbiter_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_mask;
  logic        cpu_gnt;
  logic        cpu_stall;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;

  logic        ext_req;
  logic        ext_we;
  logic        ext_lock;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [3:0]  ext_mask;
  logic        ext_gnt;
  logic        ext_rvalid;
  logic [31:0] ext_rdata;

  logic        mem_writeEn;
  logic [3:0]  mem_mMask;
  logic [31:0] mem_addr;
  logic [31:0] mem_writeData;
  logic [31:0] mem_readData;

  logic        link_active;
  logic [31:0] link_addr;
  logic        link_kill;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_mask,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  ext_req, ext_we, ext_lock, ext_addr, ext_wdata, ext_mask,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_writeEn, mem_mMask, mem_addr, mem_writeData,
    input  mem_readData,
    input  link_active, link_addr,
    output link_kill
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_mask,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output ext_req, ext_we, ext_lock, ext_addr, ext_wdata, ext_mask,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_writeEn, mem_mMask, mem_addr, mem_writeData,
    output mem_readData,
    output link_active, link_addr,
    input  link_kill
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port memory between the CPU
// MEM stage and an external master (loader/debug/DMA).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : dmem_arbiter_if.slave (cpu_*, ext_*, mem_*, link_* groups)
// Grants are combinational; read data returns one cycle after the grant.
// CPU normally wins, but a contended external request is forced through
// after STARVE_LIMIT losses, and an external locked burst keeps the port
// for up to LOCK_MAX consecutive grants.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int LOCK_MAX     = LOCK_MAX_DEF
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT);
  localparam logic [LW-1:0] LOCK_TOP   = LW'(LOCK_MAX);

  arb_state_t    state, state_nxt;
  logic [SW-1:0] starve_cnt, starve_cnt_nxt;
  logic [LW-1:0] lock_cnt, lock_cnt_nxt;
  logic          lock_hold, starved;
  logic          cpu_win, ext_win;
  logic          cpu_rvalid, ext_rvalid;
  logic [31:0]   cpu_rdata, ext_rdata;
  logic          unused_link_lsbs;

  // Reservations are word granular; the byte offset is irrelevant.
  assign unused_link_lsbs = ^bus.link_addr[1:0];

  always_comb begin
    lock_hold = (state == ARB_EXT_LOCK) && bus.ext_req && bus.ext_lock &&
                (lock_cnt < LOCK_TOP);
    starved   = bus.cpu_req && bus.ext_req && (starve_cnt == STARVE_TOP);
    cpu_win   = 1'b0;
    ext_win   = 1'b0;
    // Grants are suppressed while reset is held so nothing reaches memory.
    if (!rst) begin
      if (lock_hold || starved) begin
        ext_win = 1'b1;
      end else if (bus.cpu_req) begin
        cpu_win = 1'b1;
      end else if (bus.ext_req) begin
        ext_win = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt      = ARB_IDLE;
    starve_cnt_nxt = '0;
    lock_cnt_nxt   = '0;
    if (ext_win) begin
      state_nxt = bus.ext_lock ? ARB_EXT_LOCK : ARB_EXT;
    end else if (cpu_win) begin
      state_nxt = ARB_CPU;
    end
    if (bus.ext_req && !ext_win) begin
      starve_cnt_nxt = (starve_cnt == STARVE_TOP) ? starve_cnt
                                                  : starve_cnt + SW'(1);
    end
    // lock_cnt counts every grant of the current locked burst, including
    // the one that opened it, so a burst owns the port for at most LOCK_MAX
    // consecutive cycles. A grant after the lock was broken opens a new burst.
    if (state_nxt == ARB_EXT_LOCK) begin
      lock_cnt_nxt = ((state == ARB_EXT_LOCK) && (lock_cnt < LOCK_TOP))
                     ? lock_cnt + LW'(1) : LW'(1);
    end
  end

  always_comb begin
    bus.mem_writeEn   = 1'b0;
    bus.mem_mMask     = '0;
    bus.mem_addr      = '0;
    bus.mem_writeData = '0;
    if (cpu_win) begin
      bus.mem_writeEn   = bus.cpu_we;
      bus.mem_mMask     = bus.cpu_mask;
      bus.mem_addr      = bus.cpu_addr;
      bus.mem_writeData = bus.cpu_wdata;
    end else if (ext_win) begin
      bus.mem_writeEn   = bus.ext_we;
      bus.mem_mMask     = bus.ext_mask;
      bus.mem_addr      = bus.ext_addr;
      bus.mem_writeData = bus.ext_wdata;
    end
  end

  assign bus.cpu_gnt    = cpu_win;
  assign bus.ext_gnt    = ext_win;
  assign bus.cpu_stall  = bus.cpu_req && !cpu_win && !rst;
  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.cpu_rdata  = cpu_rdata;
  assign bus.ext_rvalid = ext_rvalid;
  assign bus.ext_rdata  = ext_rdata;
  // An external store into the reserved word breaks the CPU's LL/SC pair.
  assign bus.link_kill  = ext_win && bus.ext_we && bus.link_active &&
                          (bus.ext_addr[31:2] == bus.link_addr[31:2]);

  // Grant cycle -> read return cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
      lock_cnt   <= '0;
      cpu_rvalid <= 1'b0;
      ext_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      ext_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      lock_cnt   <= lock_cnt_nxt;
      cpu_rvalid <= cpu_win && !bus.cpu_we;
      ext_rvalid <= ext_win && !bus.ext_we;
      if (cpu_win && !bus.cpu_we) begin
        cpu_rdata <= bus.mem_readData;
      end
      if (ext_win && !bus.ext_we) begin
        ext_rdata <= bus.mem_readData;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a vector table for single-cycle
// grant/mux/link behaviour, directed sequences for starvation, locked
// bursts, lock drop, reset and read latency, and a random two-requester
// run against a reference memory.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int SL = STARVE_LIMIT_DEF;
  localparam int LM = LOCK_MAX_DEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.STARVE_LIMIT(SL), .LOCK_MAX(LM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Memory beside the arbiter: combinational read, masked write on clk.
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;

  assign bus.mem_readData = mem[bus.mem_addr[9:2]];

  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_idx] <= pre_data;
    end else if (bus.mem_writeEn) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_mMask[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_writeData[8*b +: 8];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive_cpu(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr;
    bus.cpu_wdata = wdata; bus.cpu_mask = mask;
  endtask

  task automatic drive_ext(input logic req, input logic we, input logic lock,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] mask);
    bus.ext_req = req; bus.ext_we = we; bus.ext_lock = lock; bus.ext_addr = addr;
    bus.ext_wdata = wdata; bus.ext_mask = mask;
  endtask

  task automatic idle();
    drive_cpu(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_ext(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    bus.link_active = 1'b0;
    bus.link_addr   = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        cr, cw; logic [31:0] ca, cd; logic [3:0] cm;
    logic        er, ew, el; logic [31:0] ea, ed; logic [3:0] em;
    logic        la; logic [31:0] lad;
    logic        g_cpu, g_ext, stall, we; logic [31:0] addr, wdata; logic [3:0] mask;
    logic        kill;
  } vec_t;

  vec_t vt [10];

  // random-run state
  logic        cp, cw, ep, ewe;
  logic [31:0] ca, cd, ea, ed;
  logic [3:0]  cm, em;
  int          ewait;
  logic        exp_crv, exp_erv, exp_c, exp_e;
  logic [31:0] exp_cd, exp_ed;

  initial begin
    idle();
    // Preload the memory and its reference copy while reset is held.
    for (int i = 0; i < 256; i++) begin
      pre_en = 1'b1; pre_idx = 8'(i); pre_data = 32'hC0DE_0000 | 32'(i);
      ref_mem[i] = 32'hC0DE_0000 | 32'(i);
      @(posedge clk);
      #1;
    end
    pre_en = 1'b0;
    do_reset();

    // Reset state with idle inputs.
    @(negedge clk);
    check("rst_cpu_gnt", bus.cpu_gnt, 0);
    check("rst_ext_gnt", bus.ext_gnt, 0);
    check("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    check("rst_ext_rvalid", bus.ext_rvalid, 0);
    check("rst_cpu_rdata", bus.cpu_rdata, 0);
    check("rst_ext_rdata", bus.ext_rdata, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_link_kill", bus.link_kill, 0);
    next_cycle();

    // cr cw caddr cwdata cm | er ew el eaddr ewdata em | la laddr | gC gE st we addr wdata mask kill
    vt[0] = '{0,0,32'h0,32'h0,4'h0, 0,0,0,32'h0,32'h0,4'h0, 0,32'h0, 0,0,0,0,32'h0,32'h0,4'h0,0};
    vt[1] = '{1,0,32'h100,32'h0,4'hF, 0,0,0,32'h0,32'h0,4'h0, 0,32'h0, 1,0,0,0,32'h100,32'h0,4'hF,0};
    vt[2] = '{1,1,32'h104,32'h11223344,4'h3, 0,0,0,32'h0,32'h0,4'h0, 0,32'h0, 1,0,0,1,32'h104,32'h11223344,4'h3,0};
    vt[3] = '{0,0,32'h0,32'h0,4'h0, 1,0,0,32'h10,32'h0,4'hF, 0,32'h0, 0,1,0,0,32'h10,32'h0,4'hF,0};
    vt[4] = '{0,0,32'h0,32'h0,4'h0, 1,1,0,32'h202,32'hA5A5A5A5,4'hF, 1,32'h200, 0,1,0,1,32'h202,32'hA5A5A5A5,4'hF,1};
    vt[5] = '{1,1,32'h200,32'h55,4'h1, 0,0,0,32'h0,32'h0,4'h0, 1,32'h200, 1,0,0,1,32'h200,32'h55,4'h1,0};
    vt[6] = '{1,0,32'h104,32'h0,4'hF, 1,1,0,32'h300,32'h77,4'hC, 1,32'h200, 1,0,0,0,32'h104,32'h0,4'hF,0};
    vt[7] = '{0,0,32'h0,32'h0,4'h0, 1,1,0,32'h300,32'h77,4'hC, 1,32'h200, 0,1,0,1,32'h300,32'h77,4'hC,0};
    vt[8] = '{0,0,32'h0,32'h0,4'h0, 1,1,0,32'h202,32'h99,4'hF, 0,32'h200, 0,1,0,1,32'h202,32'h99,4'hF,0};
    vt[9] = '{0,0,32'h0,32'h0,4'h0, 1,1,0,32'h200,32'h66,4'hF, 1,32'h203, 0,1,0,1,32'h200,32'h66,4'hF,1};

    for (int i = 0; i < 10; i++) begin
      drive_cpu(vt[i].cr, vt[i].cw, vt[i].ca, vt[i].cd, vt[i].cm);
      drive_ext(vt[i].er, vt[i].ew, vt[i].el, vt[i].ea, vt[i].ed, vt[i].em);
      bus.link_active = vt[i].la;
      bus.link_addr   = vt[i].lad;
      @(negedge clk);
      check($sformatf("vec%0d_cpu_gnt", i), bus.cpu_gnt, vt[i].g_cpu);
      check($sformatf("vec%0d_ext_gnt", i), bus.ext_gnt, vt[i].g_ext);
      check($sformatf("vec%0d_stall", i), bus.cpu_stall, vt[i].stall);
      check($sformatf("vec%0d_we", i), bus.mem_writeEn, vt[i].we);
      check($sformatf("vec%0d_addr", i), bus.mem_addr, vt[i].addr);
      check($sformatf("vec%0d_wdata", i), bus.mem_writeData, vt[i].wdata);
      check($sformatf("vec%0d_mask", i), bus.mem_mMask, vt[i].mask);
      check($sformatf("vec%0d_kill", i), bus.link_kill, vt[i].kill);
      next_cycle();
    end
    idle();

    // Single CPU read: grant now, data one cycle later, then held.
    do_reset();
    pre_en = 1'b1; pre_idx = 8'd64; pre_data = 32'hDEADBEEF;
    next_cycle();
    pre_en = 1'b0;
    drive_cpu(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    @(negedge clk);
    check("rd_cpu_gnt", bus.cpu_gnt, 1);
    check("rd_ext_gnt", bus.ext_gnt, 0);
    next_cycle();
    idle();
    @(negedge clk);
    check("rd_rvalid", bus.cpu_rvalid, 1);
    check("rd_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    check("rd_ext_rvalid", bus.ext_rvalid, 0);
    next_cycle();
    @(negedge clk);
    check("rd_rvalid_drop", bus.cpu_rvalid, 0);
    check("rd_rdata_hold", bus.cpu_rdata, 32'hDEADBEEF);
    next_cycle();

    // Continuous contention: cpu wins four, ext wins the fifth.
    do_reset();
    drive_cpu(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    drive_ext(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 4'hF);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("starve%0d_ext_gnt", k), bus.ext_gnt, (k % 5) == 4);
      check($sformatf("starve%0d_cpu_gnt", k), bus.cpu_gnt, (k % 5) != 4);
      check($sformatf("starve%0d_stall", k), bus.cpu_stall, (k % 5) == 4);
      check($sformatf("starve%0d_ext_rvalid", k), bus.ext_rvalid, k > 0 && ((k - 1) % 5) == 4);
      check($sformatf("starve%0d_cpu_rvalid", k), bus.cpu_rvalid, k > 0 && ((k - 1) % 5) != 4);
      if (k == 5) check("starve_ext_rdata", bus.ext_rdata, 32'hDEADBEEF);
      next_cycle();
    end
    idle();

    // Locked burst of 12 writes; cpu asks from cycle 1 until granted.
    do_reset();
    for (int c = 0; c < 13; c++) begin
      int n;
      n = (c < 8) ? c : c - 1;
      drive_ext(1'b1, 1'b1, 1'b1, 32'h80 + 32'(4 * n), 32'hB000_0000 + 32'(n), 4'hF);
      drive_cpu(c >= 1 && c <= 8, 1'b0, 32'h100, 32'h0, 4'hF);
      @(negedge clk);
      check($sformatf("lock%0d_ext_gnt", c), bus.ext_gnt, c != 8);
      check($sformatf("lock%0d_cpu_gnt", c), bus.cpu_gnt, c == 8);
      if (c == 9) begin
        check("lock_cpu_rvalid", bus.cpu_rvalid, 1);
        check("lock_cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);
      end
      next_cycle();
    end
    idle();
    next_cycle();
    for (int n = 0; n < 12; n++)
      check($sformatf("lock_mem%0d", n), mem[32 + n], 32'hB000_0000 + 32'(n));

    // Lock ends as soon as ext_req drops; cpu wins that same cycle.
    do_reset();
    drive_ext(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 4'hF);
    @(negedge clk);
    check("drop0_ext_gnt", bus.ext_gnt, 1);
    next_cycle();
    drive_cpu(1'b1, 1'b0, 32'h104, 32'h0, 4'hF);
    @(negedge clk);
    check("drop1_ext_gnt", bus.ext_gnt, 1);
    check("drop1_stall", bus.cpu_stall, 1);
    next_cycle();
    drive_ext(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("drop2_cpu_gnt", bus.cpu_gnt, 1);
    check("drop2_ext_gnt", bus.ext_gnt, 0);
    next_cycle();
    idle();

    // Reset mid-lock with a read pending on both sides.
    do_reset();
    drive_ext(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 4'hF);
    next_cycle();
    drive_cpu(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    next_cycle();
    #2 rst = 1'b1;
    #1;
    check("mrst_cpu_gnt", bus.cpu_gnt, 0);
    check("mrst_ext_gnt", bus.ext_gnt, 0);
    check("mrst_we", bus.mem_writeEn, 0);
    check("mrst_kill", bus.link_kill, 0);
    check("mrst_ext_rvalid", bus.ext_rvalid, 0);
    check("mrst_cpu_rvalid", bus.cpu_rvalid, 0);
    check("mrst_ext_rdata", bus.ext_rdata, 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("post_cpu_gnt", bus.cpu_gnt, 1);
    check("post_ext_gnt", bus.ext_gnt, 0);
    check("post_ext_rvalid", bus.ext_rvalid, 0);
    check("post_cpu_rvalid", bus.cpu_rvalid, 0);
    next_cycle();
    idle();
    @(negedge clk);
    check("post2_ext_rvalid", bus.ext_rvalid, 0);
    next_cycle();

    // Random two-requester traffic against the reference memory.
    do_reset();
    cp = 1'b0; ep = 1'b0; ewait = 0; exp_crv = 1'b0; exp_erv = 1'b0;
    cw = 1'b0; ewe = 1'b0; ca = '0; ea = '0; cd = '0; ed = '0; cm = '0; em = '0;
    exp_cd = '0; exp_ed = '0;
    for (int t = 0; t < 300; t++) begin
      if (!cp && $urandom_range(0, 9) < 6) begin
        cp = 1'b1; cw = 1'($urandom_range(0, 1)); ca = 32'($urandom_range(0, 15)) << 2;
        cd = $urandom; cm = 4'($urandom_range(1, 15));
      end
      if (!ep && $urandom_range(0, 9) < 6) begin
        ep = 1'b1; ewe = 1'($urandom_range(0, 1)); ea = 32'($urandom_range(0, 15)) << 2;
        ed = $urandom; em = 4'($urandom_range(1, 15)); ewait = 0;
      end
      drive_cpu(cp, cw, ca, cd, cm);
      drive_ext(ep, ewe, 1'b0, ea, ed, em);
      @(negedge clk);
      check("rnd_cpu_rvalid", bus.cpu_rvalid, exp_crv);
      if (exp_crv) check("rnd_cpu_rdata", bus.cpu_rdata, exp_cd);
      check("rnd_ext_rvalid", bus.ext_rvalid, exp_erv);
      if (exp_erv) check("rnd_ext_rdata", bus.ext_rdata, exp_ed);
      exp_c = cp && !(ep && ewait == SL);
      exp_e = ep && !exp_c;
      check("rnd_cpu_gnt", bus.cpu_gnt, exp_c);
      check("rnd_ext_gnt", bus.ext_gnt, exp_e);
      check("rnd_stall", bus.cpu_stall, cp && !exp_c);
      if (exp_c) check("rnd_cpu_addr", bus.mem_addr, ca);
      if (exp_e) check("rnd_ext_addr", bus.mem_addr, ea);
      exp_crv = exp_c && !cw;
      exp_erv = exp_e && !ewe;
      if (exp_c) begin
        if (!cw) exp_cd = ref_mem[ca[9:2]];
        else for (int b = 0; b < 4; b++) if (cm[b]) ref_mem[ca[9:2]][8*b +: 8] = cd[8*b +: 8];
        cp = 1'b0;
      end
      if (exp_e) begin
        if (!ewe) exp_ed = ref_mem[ea[9:2]];
        else for (int b = 0; b < 4; b++) if (em[b]) ref_mem[ea[9:2]][8*b +: 8] = ed[8*b +: 8];
        ep = 1'b0;
        ewait = 0;
      end else if (ep) begin
        ewait++;
      end
      next_cycle();
    end
    idle();
    @(negedge clk);
    check("rnd_last_cpu_rvalid", bus.cpu_rvalid, exp_crv);
    if (exp_crv) check("rnd_last_cpu_rdata", bus.cpu_rdata, exp_cd);
    check("rnd_last_ext_rvalid", bus.ext_rvalid, exp_erv);
    if (exp_erv) check("rnd_last_ext_rdata", bus.ext_rdata, exp_ed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
